// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and opcode helpers for the iterative mul/div unit
//
// Contents:
//   m_op_e       funct3 encodings of the RV32M operations
//   state_e      control states of muldiv_iter
//   is_div       operation uses the restoring divider
//   is_rem       operation returns the remainder
//   is_signed_a  rs1 is interpreted as two's complement
//   is_signed_b  rs2 is interpreted as two's complement
//   returns_high operation returns the upper half of the product

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input m_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input m_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input m_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input m_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic returns_high(input m_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - combinational UNROLL-deep shift-add / restoring-divide cell
//
// Ports:
//   div      1 selects restoring division, 0 selects shift-add multiply
//   acc      XLEN+1 upper working register (product high half / partial remainder)
//   lo       XLEN   lower working register (product low half + multiplier / quotient + dividend)
//   opb      XLEN   multiplicand or divisor magnitude
//   acc_nxt  XLEN+1 acc after UNROLL iterations
//   lo_nxt   XLEN   lo after UNROLL iterations

module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            div,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN:0]   acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   a_w;
  logic [XLEN-1:0] l_w;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  always_comb begin
    a_w     = acc;
    l_w     = lo;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    ge      = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div) begin
        // Bring the next dividend bit into the partial remainder and try
        // subtracting the divisor; the extra top bit of diff is the borrow.
        shifted = {a_w[XLEN-1:0], l_w[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        ge      = ~diff[XLEN+1];
        a_w     = ge ? diff[XLEN:0] : shifted;
        l_w     = {l_w[XLEN-2:0], ge};
      end else begin
        // Add the multiplicand when the current multiplier bit is set, then
        // shift the whole {acc, lo} product right; the carry lands in acc.
        sum = a_w + {1'b0, {XLEN{l_w[0]}} & opb};
        a_w = {1'b0, sum[XLEN:1]};
        l_w = {sum[0], l_w[XLEN-1:1]};
      end
    end
    acc_nxt = a_w;
    lo_nxt  = l_w;
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit with kill and fast paths
//
// Ports:
//   clk     rising-edge clock
//   nrst    asynchronous active-low reset
//   start   launch an operation, honoured only when idle
//   m_op    funct3 of the M-extension operation
//   a, b    rs1 / rs2 operands
//   rd_in   destination tag travelling with the operation
//   kill    abort the in-flight operation
//   busy    operation accepted and not yet completed
//   done    one-cycle completion pulse
//   res     result, valid with done and held afterwards
//   rd_out  tag of the completed operation

module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int RDW    = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [RDW-1:0]  rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic [RDW-1:0]  rd_out
);

  localparam int            NSTEP = XLEN / UNROLL;
  localparam int            CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NSTEP - 1);

  state_e state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc, acc_nxt;
  logic [XLEN-1:0] lo, lo_nxt, opb;
  m_op_e           op_q;
  logic            neg_q, neg_r;
  logic [RDW-1:0]  rd_q;
  logic            busy_q;

  // res_pend is what FIN presents; res_hold is the last result that actually
  // completed, so a kill in FIN leaves the visible result untouched.
  logic [XLEN-1:0] res_pend, res_hold;
  logic [RDW-1:0]  rd_pend, rd_hold;

  m_op_e           op_in;
  logic            accept, last, fast, op_div;
  logic            a_neg, b_neg, a_min, b_ones, b_zero;
  logic [XLEN-1:0] a_abs, b_abs, fast_res, calc_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  assign op_in  = m_op_e'(m_op);
  assign accept = (state == IDLE) && start && !kill;
  assign last   = (cnt == LAST);
  assign op_div = is_div(op_q);

  // ---------------------------------------------------------------------
  // Operand preparation and fast-path detection
  // ---------------------------------------------------------------------
  always_comb begin
    a_neg  = is_signed_a(op_in) && a[XLEN-1];
    b_neg  = is_signed_b(op_in) && b[XLEN-1];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
    a_min  = (a == {1'b1, {(XLEN-1){1'b0}}});
    b_ones = &b;
    b_zero = ~|b;
    // Divide by zero and signed overflow have architecturally fixed results,
    // so they skip the iteration entirely.
    fast   = is_div(op_in) && (b_zero || (is_signed_a(op_in) && a_min && b_ones));
    if (b_zero) begin
      fast_res = is_rem(op_in) ? a : '1;
    end else begin
      fast_res = is_rem(op_in) ? '0 : a;
    end
  end

  // ---------------------------------------------------------------------
  // Iteration cell
  // ---------------------------------------------------------------------
  muldiv_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .div     (op_div),
    .acc     (acc),
    .lo      (lo),
    .opb     (opb),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  // ---------------------------------------------------------------------
  // Sign fixup, applied to the final step's output so the corrected result
  // is captured on the same edge that enters FIN.
  // ---------------------------------------------------------------------
  always_comb begin
    prod   = {acc_nxt[XLEN-1:0], lo_nxt};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nxt : lo_nxt;
    rem_s  = neg_r ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    if (op_div) begin
      calc_res = is_rem(op_q) ? rem_s : quo_s;
    end else begin
      calc_res = returns_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = fast ? FIN : CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy   = busy_q;
    done   = (state == FIN) && !kill;
    res    = done ? res_pend : res_hold;
    rd_out = done ? rd_pend : rd_hold;
  end

  // ---------------------------------------------------------------------
  // Working registers, counter and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      res_pend <= '0;
      rd_pend  <= '0;
      res_hold <= '0;
      rd_hold  <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_in;
        rd_q  <= rd_in;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        acc   <= '0;
        lo    <= a_abs;
        opb   <= b_abs;
        cnt   <= '0;
        if (fast) begin
          res_pend <= fast_res;
          rd_pend  <= rd_in;
        end
      end else if ((state == CALC) && !kill) begin
        acc <= acc_nxt;
        lo  <= lo_nxt;
        cnt <= cnt + CW'(1);
        if (last) begin
          res_pend <= calc_res;
          rd_pend  <= rd_q;
        end
      end else if ((state == FIN) && !kill) begin
        res_hold <= res_pend;
        rd_hold  <= rd_pend;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter at UNROLL 1 and 4

module tb_muldiv_iter;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [2:0]  m_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        kill;

  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
  logic [4:0]  rdo1_w, rdo4_w;

  int n_cmp = 0;
  int n_bad = 0;

  int          n1, n4, c1, c4;
  logic [31:0] r1, r4, re1;
  logic [4:0]  rdo1, rdo4;
  logic        bf1, bf4, bk1;

  muldiv_iter #(.XLEN(32), .UNROLL(1), .RDW(5)) dut1 (
    .clk(clk), .nrst(nrst), .start(start), .m_op(m_op), .a(a), .b(b),
    .rd_in(rd_in), .kill(kill), .busy(busy1), .done(done1), .res(res1), .rd_out(rdo1_w)
  );

  muldiv_iter #(.XLEN(32), .UNROLL(4), .RDW(5)) dut4 (
    .clk(clk), .nrst(nrst), .start(start), .m_op(m_op), .a(a), .b(b),
    .rd_in(rd_in), .kill(kill), .busy(busy4), .done(done4), .res(res4), .rd_out(rdo4_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [63:0] ux = {32'b0, x};
    logic [63:0] uy = {32'b0, y};
    logic [63:0] p;
    logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int unroll);
    logic is_fast = op[2] && ((y == 0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    return is_fast ? 1 : 32 / unroll + 1;
  endfunction

  // Launch one operation and watch both units for 40 cycles.
  task automatic run(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [4:0] rd, input int kill_at, input int restart_at);
    m_op = op; a = aa; b = bb; rd_in = rd; start = 1'b1; kill = 1'b0;
    n1 = 0; n4 = 0; c1 = 0; c4 = 0; r1 = '0; r4 = '0; rdo1 = '0; rdo4 = '0;
    bf1 = 1'b0; bf4 = 1'b0; bk1 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      if (cyc == 1) begin bf1 = busy1; bf4 = busy4; end
      if (cyc == kill_at + 1) bk1 = busy1;
      if (done1) begin n1++; c1 = cyc; r1 = res1; rdo1 = rdo1_w; end
      if (done4) begin n4++; c4 = cyc; r4 = res4; rdo4 = rdo4_w; end
      if (cyc == kill_at) kill = 1'b1;
      if (cyc == restart_at) start = 1'b1;
    end
    re1 = res1;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [4:0] rd, input logic [31:0] exp);
    run(op, aa, bb, rd, 0, 0);
    check({tag, " u1 busy"},  bf1,  1);
    check({tag, " u1 dones"}, n1,   1);
    check({tag, " u1 lat"},   c1,   latency(op, aa, bb, 1));
    check({tag, " u1 res"},   r1,   exp);
    check({tag, " u1 rd"},    rdo1, rd);
    check({tag, " u4 busy"},  bf4,  1);
    check({tag, " u4 dones"}, n4,   1);
    check({tag, " u4 lat"},   c4,   latency(op, aa, bb, 4));
    check({tag, " u4 res"},   r4,   exp);
    check({tag, " u4 rd"},    rdo4, rd);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel, nd;

    nrst = 1'b0; start = 1'b0; kill = 1'b0; m_op = '0; a = '0; b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("rst busy1", busy1, 0);
    check("rst done1", done1, 0);
    check("rst res1",  res1,  0);
    check("rst rd1",   rdo1_w, 0);
    check("rst busy4", busy4, 0);
    check("rst res4",  res4,  0);
    nrst = 1'b1;
    @(negedge clk);

    op_check("mul_7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
    op_check("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000);
    op_check("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         5'd5,  32'hFFFF_FFFF);
    op_check("divu",       3'd5, 32'd100,        32'd7,         5'd6,  32'd14);
    op_check("remu",       3'd7, 32'd100,        32'd7,         5'd7,  32'd2);
    op_check("div_neg",    3'd4, 32'hFFFF_FF9C,  32'd7,         5'd8,  32'hFFFF_FFF2);
    op_check("rem_neg",    3'd6, 32'hFFFF_FF9C,  32'd7,         5'd9,  32'hFFFF_FFFE);
    op_check("div_by0",    3'd4, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF);
    op_check("rem_by0",    3'd6, 32'd5,          32'd0,         5'd11, 32'd5);
    op_check("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    op_check("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0);
    op_check("mulhu_ones", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE);

    // Kill mid-CALC: no completion, busy drops, previous result stays.
    run(3'd5, 32'd100, 32'd7, 5'd15, 10, 0);
    check("kill busy",  bk1, 0);
    check("kill dones", n1,  0);
    check("kill res",   re1, 32'hFFFF_FFFE);
    op_check("mul_after_kill", 3'd0, 32'd3, 32'd4, 5'd16, 32'd12);

    // Second start while busy is ignored.
    run(3'd0, 32'd9, 32'd9, 5'd17, 0, 5);
    check("restart u1 dones", n1, 1);
    check("restart u1 lat",   c1, 33);
    check("restart u1 res",   r1, 81);
    check("restart u4 dones", n4, 1);
    check("restart u4 res",   r4, 81);

    // kill together with start: nothing is accepted.
    m_op = 3'd0; a = 32'd5; b = 32'd5; rd_in = 5'd18; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start busy1", busy1, 0);
    check("kill_start busy4", busy4, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1 || done4) nd++;
    end
    check("kill_start dones", nd, 0);

    // Reset while iterating clears outputs asynchronously.
    m_op = 3'd0; a = 32'd11; b = 32'd13; rd_in = 5'd19; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst busy1", busy1, 0);
    check("midrst done1", done1, 0);
    check("midrst res1",  res1,  0);
    check("midrst rd1",   rdo1_w, 0);
    check("midrst busy4", busy4, 0);
    check("midrst res4",  res4,  0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'($urandom_range(1, 15));
      if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      op_check($sformatf("rnd%0d op%0d", k, rop), rop, ra, rb, 5'(k), model(rop, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
